// File: rtl/pc_gen.sv
// Fetch program-counter generator: holds the fetch PC, steps it on accepted fetches, applies redirects.
// Latency: a redirect shows up on pc_out one cycle later; a redirect raised under stall is buffered until stall drops.
// Backpressure: fetch_valid drops while stalled or pending; the PC only advances on fetch_valid & fetch_ready.
module pc_gen #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'('h80000000),
    parameter bit              C_EXT      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      pc_op,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm_data,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [XLEN-1:0] mepc,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            is_rvc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JAL    = 3'd2;
    localparam logic [2:0] OP_JALR   = 3'd3;
    localparam logic [2:0] OP_TRAP   = 3'd4;
    localparam logic [2:0] OP_MRET   = 3'd5;

    localparam logic [XLEN-1:0] CLR_BIT0  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] CLR_BIT10 = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t          state;
    logic [XLEN-1:0] pend_tgt;
    logic            pend_trap;

    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] step;
    logic            redir;
    logic            redir_trap;
    logic            tgt_mis;
    logic            take;
    logic            wins_pend;

    always_comb begin
        tgt        = '0;
        redir      = 1'b0;
        redir_trap = 1'b0;
        case (pc_op)
            OP_BRANCH: begin
                tgt   = pc_out + imm_data;
                redir = branch_taken;
            end
            OP_JAL: begin
                tgt   = pc_out + imm_data;
                redir = 1'b1;
            end
            OP_JALR: begin
                tgt   = (rs1_data + imm_data) & CLR_BIT0;
                redir = 1'b1;
            end
            OP_TRAP: begin
                tgt        = trap_vec & CLR_BIT10;
                redir      = 1'b1;
                redir_trap = 1'b1;
            end
            OP_MRET: begin
                tgt        = mepc;
                redir      = 1'b1;
                redir_trap = 1'b1;
            end
            default: ;
        endcase
    end

    // Trap/mret targets come from CSRs that are already legal, so they bypass the alignment check.
    assign tgt_mis     = redir && !redir_trap && (tgt[0] || (!C_EXT && tgt[1]));
    assign take        = redir && !tgt_mis;
    assign wins_pend   = take && (redir_trap || !pend_trap);
    assign step        = (C_EXT && is_rvc) ? XLEN'(2) : XLEN'(4);
    assign fetch_valid = (state == RUN) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BOOT;
            pc_out        <= RESET_ADDR;
            pend_tgt      <= '0;
            pend_trap     <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= 1'b0;
            if (state != BOOT && tgt_mis) begin
                misalign      <= 1'b1;
                misalign_addr <= tgt;
            end
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (!stall) begin
                        if (take)
                            pc_out <= tgt;
                        else if (fetch_valid && fetch_ready && !tgt_mis)
                            pc_out <= pc_out + step;
                    end else if (take) begin
                        pend_tgt  <= tgt;
                        pend_trap <= redir_trap;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    // A buffered trap/mret can only be displaced by another trap/mret.
                    if (stall) begin
                        if (wins_pend) begin
                            pend_tgt  <= tgt;
                            pend_trap <= redir_trap;
                        end
                    end else begin
                        pc_out    <= wins_pend ? tgt : pend_tgt;
                        pend_trap <= 1'b0;
                        state     <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule
